// File: rtl/fc_pkg.sv
// Shared Fibre Channel receive definitions: word classes, ordered-set constants
// and the primitive recognition count.
package fc;

    typedef enum logic [3:0] {
        SEQ_NONE,
        SEQ_DATA,
        SEQ_UNKNOWN,
        SEQ_IDLE,
        SEQ_ARBFF,
        SEQ_OLS,
        SEQ_NOS,
        SEQ_LR,
        SEQ_LRR
    } rx_seq_t;

    localparam int unsigned SEQ_RECOGNIZE_COUNT = 3;

    localparam logic [31:0] IDLE  = 32'hBC95B5B5;
    localparam logic [31:0] ARBFF = 32'hBC94FFFF;
    localparam logic [31:0] OLS   = 32'hBC358A55;
    localparam logic [31:0] NOS   = 32'hBC55BF45;
    localparam logic [31:0] LR    = 32'hBC49BF49;
    localparam logic [31:0] LRR   = 32'hBC35BF49;

    // Only these classes are eligible to become the recognized sequence.
    function automatic logic is_primitive(rx_seq_t c);
        return (c == SEQ_IDLE) || (c == SEQ_ARBFF) || (c == SEQ_OLS) ||
               (c == SEQ_NOS)  || (c == SEQ_LR)    || (c == SEQ_LRR);
    endfunction

endpackage

// File: rtl/fc_os_decode.sv
// Combinational ordered-set classifier for one decoded 32-bit receive word.
module fc_os_decode
    import fc::*;
(
    input  logic [31:0] data,
    input  logic [3:0]  datak,
    output rx_seq_t     cls
);

    always_comb begin
        cls = SEQ_UNKNOWN;
        if (datak == 4'b0000) begin
            cls = SEQ_DATA;
        end else if (datak == 4'b1000) begin
            case (data)
                IDLE:    cls = SEQ_IDLE;
                ARBFF:   cls = SEQ_ARBFF;
                OLS:     cls = SEQ_OLS;
                NOS:     cls = SEQ_NOS;
                LR:      cls = SEQ_LR;
                LRR:     cls = SEQ_LRR;
                default: cls = SEQ_UNKNOWN;
            endcase
        end
    end

endmodule

// File: rtl/fc_state_rx.sv
// Receive-side primitive recognizer: tracks runs of identical ordered sets and
// latches a primitive sequence after three in a row; counts unknown K-words.
module fc_state_rx
    import fc::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic [3:0]  datak,
    input  logic        valid,
    input  logic        err_clear,
    output rx_seq_t     rx_word,
    output rx_seq_t     rx_seq,
    output logic        rx_seq_change,
    output logic [15:0] code_err_count
);

    localparam logic [1:0] RUN_LATCH = 2'(SEQ_RECOGNIZE_COUNT);

    rx_seq_t     cls;
    rx_seq_t     rx_word_q, rx_word_d;
    rx_seq_t     rx_seq_q, rx_seq_d;
    rx_seq_t     last_q, last_d;
    logic [1:0]  run_q, run_d;
    logic        change_q, change_d;
    logic [15:0] err_q, err_d;

    fc_os_decode u_decode (
        .data  (data),
        .datak (datak),
        .cls   (cls)
    );

    always_comb begin
        rx_word_d = rx_word_q;
        rx_seq_d  = rx_seq_q;
        last_d    = last_q;
        run_d     = run_q;
        change_d  = 1'b0;
        err_d     = err_q;
        if (valid) begin
            rx_word_d = cls;
            if (cls == last_q) begin
                if (run_q != 2'd3) run_d = run_q + 2'd1;
            end else begin
                last_d = cls;
                run_d  = 2'd1;
            end
            // Re-recognizing the already latched class is not a change.
            if (run_d == RUN_LATCH && is_primitive(cls) && cls != rx_seq_q) begin
                rx_seq_d = cls;
                change_d = 1'b1;
            end
            if (cls == SEQ_UNKNOWN && err_q != 16'hFFFF) err_d = err_q + 16'd1;
        end
        if (err_clear) err_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_word_q <= SEQ_NONE;
            rx_seq_q  <= SEQ_NONE;
            last_q    <= SEQ_NONE;
            run_q     <= 2'd0;
            change_q  <= 1'b0;
            err_q     <= 16'd0;
        end else begin
            rx_word_q <= rx_word_d;
            rx_seq_q  <= rx_seq_d;
            last_q    <= last_d;
            run_q     <= run_d;
            change_q  <= change_d;
            err_q     <= err_d;
        end
    end

    assign rx_word        = rx_word_q;
    assign rx_seq         = rx_seq_q;
    assign rx_seq_change  = change_q;
    assign code_err_count = err_q;

endmodule

// File: tb/tb_fc_state_rx.sv
// Directed self-checking bench for fc_state_rx.
module tb_fc_state_rx;
    import fc::*;

    logic        clk;
    logic        reset;
    logic [31:0] data;
    logic [3:0]  datak;
    logic        valid;
    logic        err_clear;
    rx_seq_t     rx_word;
    rx_seq_t     rx_seq;
    logic        rx_seq_change;
    logic [15:0] code_err_count;

    int n_tests;
    int n_fail;

    fc_state_rx dut (
        .clk            (clk),
        .reset          (reset),
        .data           (data),
        .datak          (datak),
        .valid          (valid),
        .err_clear      (err_clear),
        .rx_word        (rx_word),
        .rx_seq         (rx_seq),
        .rx_seq_change  (rx_seq_change),
        .code_err_count (code_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one valid word for a single edge; outputs are sampled 1 ns later.
    task automatic send(input logic [31:0] w, input logic [3:0] k);
        data  = w;
        datak = k;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        data      = '0;
        datak     = '0;
        valid     = 1'b0;
        err_clear = 1'b0;
        gap(2);
        reset = 1'b0;
        gap(1);

        check("rst_rx_word", rx_word, SEQ_NONE);
        check("rst_rx_seq", rx_seq, SEQ_NONE);
        check("rst_change", rx_seq_change, 0);
        check("rst_errcnt", code_err_count, 0);

        // Three IDLEs latch SEQ_IDLE with a single pulse.
        send(IDLE, 4'b1000);
        send(IDLE, 4'b1000);
        check("idle2_seq", rx_seq, SEQ_NONE);
        check("idle2_change", rx_seq_change, 0);
        send(IDLE, 4'b1000);
        check("idle3_seq", rx_seq, SEQ_IDLE);
        check("idle3_change", rx_seq_change, 1);
        check("idle3_word", rx_word, SEQ_IDLE);
        gap(1);
        check("idle_pulse_end", rx_seq_change, 0);
        check("idle_hold", rx_seq, SEQ_IDLE);

        // A data word breaks a NOS run.
        send(NOS, 4'b1000);
        send(NOS, 4'b1000);
        check("nos2_seq", rx_seq, SEQ_IDLE);
        send(32'h12345678, 4'b0000);
        check("data_word", rx_word, SEQ_DATA);
        check("data_seq", rx_seq, SEQ_IDLE);
        send(NOS, 4'b1000);
        check("nos_after_data", rx_seq, SEQ_IDLE);
        send(NOS, 4'b1000);
        check("nos_b2_seq", rx_seq, SEQ_IDLE);
        check("nos_b2_change", rx_seq_change, 0);
        send(NOS, 4'b1000);
        check("nos_b3_seq", rx_seq, SEQ_NOS);
        check("nos_b3_change", rx_seq_change, 1);
        gap(1);
        check("nos_pulse_end", rx_seq_change, 0);

        // Idle gaps do not break a run.
        send(LR, 4'b1000);
        gap(2);
        send(LR, 4'b1000);
        gap(2);
        check("lr_gap_seq", rx_seq, SEQ_NOS);
        send(LR, 4'b1000);
        check("lr_seq", rx_seq, SEQ_LR);
        check("lr_change", rx_seq_change, 1);

        // Repeated OLS after latch gives no further pulse.
        for (int i = 0; i < 3; i++) send(OLS, 4'b1000);
        check("ols_seq", rx_seq, SEQ_OLS);
        check("ols_change", rx_seq_change, 1);
        for (int i = 0; i < 5; i++) begin
            send(OLS, 4'b1000);
            check($sformatf("ols_more%0d_change", i), rx_seq_change, 0);
        end
        check("ols_more_seq", rx_seq, SEQ_OLS);

        // Alternating classes never latch.
        for (int i = 0; i < 3; i++) begin
            send(IDLE, 4'b1000);
            send(ARBFF, 4'b1000);
        end
        check("alt_seq", rx_seq, SEQ_OLS);
        for (int i = 0; i < 3; i++) send(ARBFF, 4'b1000);
        check("arbff_seq", rx_seq, SEQ_ARBFF);

        // Unknown K-words.
        send(32'hBC000000, 4'b1000);
        check("unk1_word", rx_word, SEQ_UNKNOWN);
        check("unk1_cnt", code_err_count, 1);
        check("unk1_seq", rx_seq, SEQ_ARBFF);
        send(IDLE, 4'b1100);
        check("unk2_word", rx_word, SEQ_UNKNOWN);
        check("unk2_cnt", code_err_count, 2);
        err_clear = 1'b1;
        gap(1);
        err_clear = 1'b0;
        check("clear_cnt", code_err_count, 0);
        for (int i = 0; i < 65535; i++) send(32'hBC000000, 4'b1000);
        check("cnt_full", code_err_count, 16'hFFFF);
        send(32'hBC000000, 4'b1000);
        check("cnt_sat", code_err_count, 16'hFFFF);
        err_clear = 1'b1;
        send(32'hBC000000, 4'b1000);
        err_clear = 1'b0;
        check("clear_wins", code_err_count, 0);

        // Asynchronous reset mid-run.
        send(32'hBC000000, 4'b1000);
        send(LRR, 4'b1000);
        send(LRR, 4'b1000);
        check("pre_rst_cnt", code_err_count, 1);
        reset = 1'b1;
        #1;
        check("arst_word", rx_word, SEQ_NONE);
        check("arst_seq", rx_seq, SEQ_NONE);
        check("arst_cnt", code_err_count, 0);
        reset = 1'b0;
        gap(1);
        send(LRR, 4'b1000);
        check("post_rst_seq", rx_seq, SEQ_NONE);
        check("post_rst_change", rx_seq_change, 0);
        check("post_rst_word", rx_word, SEQ_LRR);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
